quad_decoder: RTL and testbench

Quadrature decoder placed directly upstream of the 4-bit up/down counter stage. It takes two asynchronous encoder channels, synchronises and glitch-filters them, and tracks the 2-bit Gray position. Each legal position change produces a one-cycle `step` pulse with a direction bit. `step` qualifies the counter update and `dir` drives the counter's up/down select (1 = up). Illegal double transitions are flagged in a sticky error bit.

---
 rtl/quad_pkg.sv | 31 +++
 rtl/glitch_filter.sv | 49 ++++
 rtl/quad_decoder.sv | 121 ++++++++++++
 tb/tb_quad_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder.
package quad_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Gray-coded encoder positions, forward order 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] POS_00 = 2'b00;
  localparam logic [1:0] POS_01 = 2'b01;
  localparam logic [1:0] POS_11 = 2'b11;
  localparam logic [1:0] POS_10 = 2'b10;

  // Classify a position change as {legal, fwd}.
  // legal: exactly one channel changed. fwd: cur is the forward neighbour of prev.
  // An unchanged position reports legal=0; callers check equality first.
  function automatic logic [1:0] pos_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] nxt_fwd;
    logic       legal;
    case (prev)
      POS_00:  nxt_fwd = POS_01;
      POS_01:  nxt_fwd = POS_11;
      POS_11:  nxt_fwd = POS_10;
      default: nxt_fwd = POS_00;
    endcase
    legal = ^(prev ^ cur);
    return {legal, legal && (cur == nxt_fwd)};
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one encoder channel.
module glitch_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic areset_n,
  input  logic i_x,
  output logic o_filt
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          r_meta;
  logic          r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_filt;

  // Bring the asynchronous channel into the clk domain.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_x;
      r_sync <= r_meta;
    end
  end

  // Accept a new level only after it has differed from filt for FILTER_LEN consecutive edges.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync != r_filt) begin
      if (r_cnt == CNT_LAST) begin
        r_filt <= r_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filters both channels, tracks the Gray position and
// emits one-cycle step pulses with direction, plus a sticky illegal-transition flag.
module quad_decoder #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic areset_n,
  input  logic ch_a,
  input  logic ch_b,
  input  logic err_clr,
  output logic ready,
  output logic step,
  output logic dir,
  output logic err
);

  import quad_pkg::*;

  localparam int SW = $clog2(FILTER_LEN + 3);
  // Settle counter value at which INIT hands over; makes ready rise on edge FILTER_LEN+3.
  localparam logic [SW-1:0] SETTLE_LAST = SW'(FILTER_LEN + 2);

  logic          w_filt_a;
  logic          w_filt_b;
  logic [1:0]    w_pos;
  logic [1:0]    w_chk;

  state_t        r_state;
  logic [SW-1:0] r_settle;
  logic [1:0]    r_prev_pos;
  logic          r_ready;
  logic          r_step;
  logic          r_dir;
  logic          r_err;

  state_t        w_state_nxt;
  logic [SW-1:0] w_settle_nxt;
  logic [1:0]    w_prev_nxt;
  logic          w_ready_nxt;
  logic          w_step_nxt;
  logic          w_dir_nxt;
  logic          w_err_nxt;

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk      (clk),
    .areset_n (areset_n),
    .i_x      (ch_a),
    .o_filt   (w_filt_a)
  );

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk      (clk),
    .areset_n (areset_n),
    .i_x      (ch_b),
    .o_filt   (w_filt_b)
  );

  assign w_pos = {w_filt_a, w_filt_b};
  assign w_chk = pos_step(r_prev_pos, w_pos);

  // Next-state and next-output logic; err set wins over err_clr.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_prev_nxt   = r_prev_pos;
    w_ready_nxt  = r_ready;
    w_step_nxt   = 1'b0;
    w_dir_nxt    = r_dir;
    w_err_nxt    = r_err & ~err_clr;
    case (r_state)
      ST_INIT: begin
        if (r_settle == SETTLE_LAST) begin
          w_state_nxt = ST_TRACK;
          w_prev_nxt  = w_pos;
          w_ready_nxt = 1'b1;
        end else begin
          w_settle_nxt = r_settle + SW'(1);
        end
      end
      ST_TRACK: begin
        w_prev_nxt = w_pos;
        if (w_pos != r_prev_pos) begin
          if (w_chk[1]) begin
            w_step_nxt = 1'b1;
            w_dir_nxt  = w_chk[0];
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State, position history and registered outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state    <= ST_INIT;
      r_settle   <= '0;
      r_prev_pos <= POS_00;
      r_ready    <= 1'b0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_settle   <= w_settle_nxt;
      r_prev_pos <= w_prev_nxt;
      r_ready    <= w_ready_nxt;
      r_step     <= w_step_nxt;
      r_dir      <= w_dir_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign ready = r_ready;
  assign step  = r_step;
  assign dir   = r_dir;
  assign err   = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder at FILTER_LEN=3.
module tb_quad_decoder;

  logic clk;
  logic areset_n;
  logic ch_a;
  logic ch_b;
  logic err_clr;
  logic ready;
  logic step;
  logic dir;
  logic err;

  int total;
  int bad;

  quad_decoder #(.FILTER_LEN(3)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .ch_a     (ch_a),
    .ch_b     (ch_b),
    .err_clr  (err_clr),
    .ready    (ready),
    .step     (step),
    .dir      (dir),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive p0 at a falling edge, switch to p1 after n0 cycles, observe for total_cyc cycles.
  // Observation index j means "sampled after the j-th rising edge since the drive".
  task automatic run_pattern(input logic [1:0] p0, input int n0, input logic [1:0] p1,
                             input int total_cyc, output int pulses, output int first_at,
                             output logic first_dir, output logic err_seen);
    pulses = 0; first_at = 0; first_dir = 1'b0; err_seen = 1'b0;
    @(negedge clk);
    {ch_a, ch_b} = p0;
    for (int j = 1; j <= total_cyc; j++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        pulses++;
        if (first_at == 0) begin
          first_at  = j;
          first_dir = dir;
        end
      end
      if (err === 1'b1) err_seen = 1'b1;
      if (j == n0) {ch_a, ch_b} = p1;
    end
  endtask

  task automatic do_reset(input logic [1:0] p);
    @(negedge clk);
    areset_n = 1'b0;
    {ch_a, ch_b} = p;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    areset_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    int pulses;
    logic err_seen;
    pulses = 0; err_seen = 1'b0;
    areset_n = 1'b0; ch_a = 1'b1; ch_b = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ready, step, dir, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0000", {ready, step, dir, err});
    end
    areset_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (step === 1'b1) pulses++;
      if (err === 1'b1) err_seen = 1'b1;
      if (j == 5) begin
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL ready_edge5 got=%b exp=0", ready); end
      end
      if (j == 6) begin
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL ready_edge6 got=%b exp=1", ready); end
      end
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL reset_no_step got=%0d exp=0", pulses); end
    total++;
    if (err_seen !== 1'b0) begin bad++; $display("FAIL reset_no_err got=%b exp=0", err_seen); end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    int pulses, first_at;
    logic fdir, eseen;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      run_pattern(seq[i], 8, seq[i], 8, pulses, first_at, fdir, eseen);
      total++;
      if (pulses !== 1) begin bad++; $display("FAIL fwd_pulses[%0d] got=%0d exp=1", i, pulses); end
      total++;
      if (first_at !== 6) begin bad++; $display("FAIL fwd_latency[%0d] got=%0d exp=6", i, first_at); end
      total++;
      if (fdir !== 1'b1) begin bad++; $display("FAIL fwd_dir[%0d] got=%b exp=1", i, fdir); end
      total++;
      if (eseen !== 1'b0) begin bad++; $display("FAIL fwd_err[%0d] got=%b exp=0", i, eseen); end
    end
  endtask

  task automatic test_reverse();
    logic [1:0] seq [4];
    int pulses, first_at;
    logic fdir, eseen;
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      run_pattern(seq[i], 8, seq[i], 8, pulses, first_at, fdir, eseen);
      total++;
      if (pulses !== 1) begin bad++; $display("FAIL rev_pulses[%0d] got=%0d exp=1", i, pulses); end
      total++;
      if (fdir !== 1'b0) begin bad++; $display("FAIL rev_dir[%0d] got=%b exp=0", i, fdir); end
    end
    total++;
    if (dir !== 1'b0) begin bad++; $display("FAIL rev_dir_hold got=%b exp=0", dir); end
    run_pattern(2'b01, 8, 2'b01, 8, pulses, first_at, fdir, eseen);
    total++;
    if (pulses !== 1 || fdir !== 1'b1) begin
      bad++; $display("FAIL rev_then_fwd got=%0d/%b exp=1/1", pulses, fdir);
    end
    // Return to 00 with a reverse step.
    run_pattern(2'b00, 8, 2'b00, 8, pulses, first_at, fdir, eseen);
    total++;
    if (pulses !== 1 || fdir !== 1'b0) begin
      bad++; $display("FAIL back_to_00 got=%0d/%b exp=1/0", pulses, fdir);
    end
  endtask

  task automatic test_glitch();
    int pulses, first_at;
    logic fdir, eseen;
    // 2-cycle pulse on ch_a: rejected.
    run_pattern(2'b10, 2, 2'b00, 14, pulses, first_at, fdir, eseen);
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL glitch2_pulses got=%0d exp=0", pulses); end
    total++;
    if (dir !== 1'b0) begin bad++; $display("FAIL glitch2_dir got=%b exp=0", dir); end
    // 3-cycle pulse: 00->10 (reverse) then 10->00 (forward).
    run_pattern(2'b10, 3, 2'b00, 14, pulses, first_at, fdir, eseen);
    total++;
    if (pulses !== 2) begin bad++; $display("FAIL glitch3_pulses got=%0d exp=2", pulses); end
    total++;
    if (first_at !== 6 || fdir !== 1'b0) begin
      bad++; $display("FAIL glitch3_first got=%0d/%b exp=6/0", first_at, fdir);
    end
    total++;
    if (dir !== 1'b1) begin bad++; $display("FAIL glitch3_dir_end got=%b exp=1", dir); end
  endtask

  task automatic test_error();
    int pulses, first_at;
    logic fdir, eseen;
    run_pattern(2'b11, 10, 2'b11, 10, pulses, first_at, fdir, eseen);
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL err_no_step got=%0d exp=0", pulses); end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
    total++;
    if (dir !== 1'b1) begin bad++; $display("FAIL err_dir_hold got=%b exp=1", dir); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    // 11 -> 00 double transition; err_clr asserted for exactly the setting edge.
    @(negedge clk);
    {ch_a, ch_b} = 2'b00;
    repeat (5) @(negedge clk);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_pre_set got=%b exp=0", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_set_over_clr got=%b exp=1", err); end
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    {ch_a, ch_b} = 2'b01;
    repeat (3) @(negedge clk);
    #2 areset_n = 1'b0;
    #1;
    total++;
    if ({ready, step, dir, err} !== 4'b0000) begin
      bad++; $display("FAIL mid_reset_async got=%b exp=0000", {ready, step, dir, err});
    end
    @(negedge clk);
    areset_n = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      if (step === 1'b1) pulses++;
      if (j == 5) begin
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL mid_ready_edge5 got=%b exp=0", ready); end
      end
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL mid_no_step got=%0d exp=0", pulses); end
    total++;
    if (ready !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL mid_after got=%b%b exp=10", ready, err);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    do_reset(2'b00);
    test_forward();
    test_reverse();
    test_glitch();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
